// File: rtl/start_change_udp_formatter.sv
// start_change_udp_formatter: turns one StartViewChange request from the
// broadcast FSM into a UDP meta beat plus a fixed 16-byte payload.
// Optional build macro START_CHANGE_FMT_CNT_EN adds the msgs_sent_cnt output.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a valid, once raised, stays high with its fields stable
// until that transfer happens.
module start_change_udp_formatter #(
    parameter int          DATA_W   = 512,
    parameter logic [31:0] MSG_TYPE = 32'd3,
    parameter int          PAD_W    = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       my_ip,
    input  logic [15:0]       my_port,
    input  logic [31:0]       my_index,
    input  logic [63:0]       curr_view,
    input  logic              store_config_ram_rd,
    input  logic [31:0]       config_ram_rd_resp_ip,
    input  logic [15:0]       config_ram_rd_resp_port,
    input  logic              start_change_to_udp_meta_val,
    output logic              to_udp_start_change_meta_rdy,
    input  logic              start_change_to_udp_data_val,
    input  logic              start_change_to_udp_data_last,
    output logic              to_udp_start_change_data_rdy,
    output logic              udp_tx_meta_val,
    output logic [31:0]       udp_tx_meta_src_ip,
    output logic [31:0]       udp_tx_meta_dst_ip,
    output logic [15:0]       udp_tx_meta_src_port,
    output logic [15:0]       udp_tx_meta_dst_port,
    output logic [15:0]       udp_tx_meta_len,
    input  logic              udp_tx_meta_rdy,
    output logic              udp_tx_data_val,
    output logic [DATA_W-1:0] udp_tx_data,
    output logic              udp_tx_data_last,
    output logic [PAD_W-1:0]  udp_tx_data_padbytes,
    input  logic              udp_tx_data_rdy,
    output logic [1:0]        dbg_state
`ifdef START_CHANGE_FMT_CNT_EN
    ,
    output logic [31:0]       msgs_sent_cnt
`endif
);

    localparam int NUM_BEATS = (DATA_W == 64) ? 2 : 1;
    localparam int EXT_W     = NUM_BEATS * DATA_W;
    localparam int PAD_BYTES = EXT_W / 8 - 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        META_OUT  = 2'd2,
        DATA_OUT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] stage_ip_q, stage_ip_d;
    logic [15:0] stage_port_q, stage_port_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic [15:0] dst_port_q, dst_port_d;
    logic [63:0] view_q, view_d;
    logic [31:0] index_q, index_d;
    logic        beat_q, beat_d;
    logic        last_beat;
    logic        data_take;
    logic [127:0]     payload;
    logic [EXT_W-1:0] payload_ext;

    // The message is always one upstream beat, so data_last never changes
    // the outcome: a beat with last=0 is still taken as the final one.
    assign data_take = start_change_to_udp_data_val &
                       (start_change_to_udp_data_last | ~start_change_to_udp_data_last);

    assign last_beat = (NUM_BEATS == 1) || beat_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            stage_ip_q   <= '0;
            stage_port_q <= '0;
            dst_ip_q     <= '0;
            dst_port_q   <= '0;
            view_q       <= '0;
            index_q      <= '0;
            beat_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_ip_q   <= stage_ip_d;
            stage_port_q <= stage_port_d;
            dst_ip_q     <= dst_ip_d;
            dst_port_q   <= dst_port_d;
            view_q       <= view_d;
            index_q      <= index_d;
            beat_q       <= beat_d;
        end
    end

    // Next-state, register updates and handshake outputs
    always_comb begin
        state_d      = state_q;
        stage_ip_d   = stage_ip_q;
        stage_port_d = stage_port_q;
        dst_ip_d     = dst_ip_q;
        dst_port_d   = dst_port_q;
        view_d       = view_q;
        index_d      = index_q;
        beat_d       = beat_q;
        to_udp_start_change_meta_rdy = 1'b0;
        to_udp_start_change_data_rdy = 1'b0;
        udp_tx_meta_val              = 1'b0;
        udp_tx_data_val              = 1'b0;

        // Staging follows every RAM response so the next peer's lookup can
        // overlap the current transmit; the active copy is taken from the
        // old staging value on meta accept.
        if (store_config_ram_rd) begin
            stage_ip_d   = config_ram_rd_resp_ip;
            stage_port_d = config_ram_rd_resp_port;
        end

        case (state_q)
            IDLE: begin
                to_udp_start_change_meta_rdy = 1'b1;
                if (start_change_to_udp_meta_val) begin
                    dst_ip_d   = stage_ip_q;
                    dst_port_d = stage_port_q;
                    state_d    = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                to_udp_start_change_data_rdy = 1'b1;
                if (data_take) begin
                    view_d  = curr_view;
                    index_d = my_index;
                    beat_d  = 1'b0;
                    state_d = META_OUT;
                end
            end
            META_OUT: begin
                udp_tx_meta_val = 1'b1;
                if (udp_tx_meta_rdy) begin
                    state_d = DATA_OUT;
                end
            end
            DATA_OUT: begin
                udp_tx_data_val = 1'b1;
                if (udp_tx_data_rdy) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload image, big-endian, left-aligned over all beats
    always_comb begin
        payload     = {MSG_TYPE, view_q, index_q};
        payload_ext = '0;
        payload_ext[EXT_W-1 -: 128] = payload;
    end

    assign udp_tx_meta_src_ip   = my_ip;
    assign udp_tx_meta_src_port = my_port;
    assign udp_tx_meta_dst_ip   = dst_ip_q;
    assign udp_tx_meta_dst_port = dst_port_q;
    assign udp_tx_meta_len      = 16'd16;

    assign udp_tx_data          = beat_q ? payload_ext[DATA_W-1:0]
                                         : payload_ext[EXT_W-1 -: DATA_W];
    assign udp_tx_data_last     = udp_tx_data_val && last_beat;
    assign udp_tx_data_padbytes = (udp_tx_data_val && last_beat) ? PAD_W'(PAD_BYTES) : '0;
    assign dbg_state            = state_q;

`ifdef START_CHANGE_FMT_CNT_EN
    logic [31:0] msgs_sent_cnt_q, msgs_sent_cnt_d;

    // Count completed messages (last-beat transfers), wrapping naturally
    always_comb begin
        msgs_sent_cnt_d = msgs_sent_cnt_q;
        if (state_q == DATA_OUT && udp_tx_data_rdy && last_beat) begin
            msgs_sent_cnt_d = msgs_sent_cnt_q + 32'd1;
        end
    end

    // Message counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            msgs_sent_cnt_q <= '0;
        end else begin
            msgs_sent_cnt_q <= msgs_sent_cnt_d;
        end
    end

    assign msgs_sent_cnt = msgs_sent_cnt_q;
`endif

endmodule
